// File: rtl/sram_unit_pkg.sv
// sram_unit_pkg: shared default sizes and word/address/mask types for the SRAM wrapper
package sram_unit_pkg;
  localparam int NUM_WMASKS_DEF = 4;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 10;
  typedef logic [ADDR_WIDTH_DEF-1:0] addr_t;
  typedef logic [DATA_WIDTH_DEF-1:0] word_t;
  typedef logic [NUM_WMASKS_DEF-1:0] wmask_t;
endpackage

// File: rtl/sram_1rw1r_array.sv
// sram_1rw1r_array: byte-masked read/write port plus read-only port over an unreset storage array
module sram_1rw1r_array
  import sram_unit_pkg::*;
#(
  parameter int NUM_WMASKS = NUM_WMASKS_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  we0,
  input  logic                  re0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  input  logic                  re1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  // Non-blocking reads see pre-write data on a same-address collision
  always_ff @(posedge clk) begin
    if (re0) dout0 <= mem[addr0];
    if (re1) dout1 <= mem[addr1];
    if (we0)
      for (int i = 0; i < NUM_WMASKS; i++)
        if (wmask0[i]) mem[addr0][8*i +: 8] <= din0[8*i +: 8];
  end
endmodule

// File: rtl/sram_unit.sv
// sram_unit: 2-port SRAM wrapper with resettable outputs and a self-incrementing port-1 read pointer
module sram_unit
  import sram_unit_pkg::*;
#(
  parameter int NUM_WMASKS = NUM_WMASKS_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
`ifdef USE_POWER_PINS
  inout  wire                   VDD,
  inout  wire                   VSS,
`endif
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  csb0,
  input  logic                  csb1,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic [DATA_WIDTH-1:0] dout1
);
  logic                  we0, re0, re1, clr0, clr1;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [DATA_WIDTH-1:0] q0, q1;
  assign we0 = !rst && !csb0 && !web0;
  assign re0 = !rst && !csb0 && web0;
  assign re1 = !rst && !csb1;
  // The array outputs have no reset, so a flag forces zero until each port's first read after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      clr0   <= 1'b1;
      clr1   <= 1'b1;
    end else begin
      if (re0) clr0 <= 1'b0;
      if (re1) begin
        clr1   <= 1'b0;
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end
  assign dout0 = clr0 ? '0 : q0;
  assign dout1 = clr1 ? '0 : q1;
  sram_1rw1r_array #(
    .NUM_WMASKS(NUM_WMASKS),
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk   (clk),
    .we0   (we0),
    .re0   (re0),
    .wmask0(wmask0),
    .addr0 (addr0),
    .din0  (din0),
    .dout0 (q0),
    .re1   (re1),
    .addr1 (rd_ptr),
    .dout1 (q1)
  );
endmodule

// File: tb/tb_sram_unit.sv
// tb_sram_unit: directed and randomized checks of sram_unit against an array-based memory model
module tb_sram_unit;
  import sram_unit_pkg::*;
  localparam int DEPTH = 1 << ADDR_WIDTH_DEF;
  logic   clk = 1'b0, rst = 1'b1, csb0 = 1'b1, csb1 = 1'b1, web0 = 1'b1;
  wmask_t wmask0 = '0;
  addr_t  addr0 = '0;
  word_t  din0 = '0;
  word_t  dout0, dout1;
  int     passed = 0, total = 0;
  word_t  m [DEPTH];
  word_t  exp0 = '0, exp1 = '0;
  int     ptr = 0;

  always #5 clk = ~clk;

  sram_unit dut (
    .clk(clk), .rst(rst), .csb0(csb0), .csb1(csb1), .web0(web0),
    .wmask0(wmask0), .addr0(addr0), .din0(din0), .dout0(dout0), .dout1(dout1)
  );

  // Model: reads see memory as it was before this edge's write
  task automatic cycle();
    if (!csb0 && web0) exp0 = m[addr0];
    if (!csb1) begin
      exp1 = m[ptr];
      ptr = (ptr + 1) % DEPTH;
    end
    if (!csb0 && !web0)
      for (int i = 0; i < NUM_WMASKS_DEF; i++)
        if (wmask0[i]) m[addr0][8*i +: 8] = din0[8*i +: 8];
    @(posedge clk);
    #1;
  endtask

  task automatic p0(input logic cs, input logic wn, input wmask_t mk, input addr_t a, input word_t d);
    csb0 = cs; web0 = wn; wmask0 = mk; addr0 = a; din0 = d;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (dout0 !== 32'h0) $display("FAIL reset_dout0 got %h want %h", dout0, 32'h0); else passed++;
    total++; if (dout1 !== 32'h0) $display("FAIL reset_dout1 got %h want %h", dout1, 32'h0); else passed++;
    rst = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      p0(1'b0, 1'b0, 4'hf, addr_t'(a), word_t'($urandom));
      cycle();
    end
    p0(1'b1, 1'b1, '0, '0, '0);
    cycle();
    total++; if (dout0 !== 32'h0) $display("FAIL reset_after_fill got %h want %h", dout0, 32'h0); else passed++;
  endtask

  task automatic test_write_read();
    p0(1'b0, 1'b0, 4'hf, 10'd0, 32'haaaaaaaa);
    cycle();
    total++; if (dout0 !== 32'h0) $display("FAIL no_write_through got %h want %h", dout0, 32'h0); else passed++;
    p0(1'b0, 1'b1, '0, 10'd0, '0);
    cycle();
    total++; if (dout0 !== 32'haaaaaaaa) $display("FAIL read_addr0 got %h want %h", dout0, 32'haaaaaaaa); else passed++;
    for (int k = 0; k < 3; k++) begin
      p0(1'b1, 1'(k), wmask_t'($urandom), addr_t'($urandom), word_t'($urandom));
      cycle();
      total++; if (dout0 !== 32'haaaaaaaa) $display("FAIL idle_hold got %h want %h", dout0, 32'haaaaaaaa); else passed++;
    end
  endtask

  task automatic test_masked_write();
    p0(1'b0, 1'b0, 4'hf, 10'd5, 32'hffffffff);
    cycle();
    p0(1'b0, 1'b0, 4'b0101, 10'd5, 32'h12345678);
    cycle();
    p0(1'b0, 1'b1, '0, 10'd5, '0);
    cycle();
    total++; if (dout0 !== 32'hff34ff78) $display("FAIL masked_write got %h want %h", dout0, 32'hff34ff78); else passed++;
    p0(1'b0, 1'b0, 4'b0000, 10'd5, 32'h0);
    cycle();
    p0(1'b0, 1'b1, '0, 10'd5, '0);
    cycle();
    total++; if (dout0 !== 32'hff34ff78) $display("FAIL zero_mask got %h want %h", dout0, 32'hff34ff78); else passed++;
  endtask

  task automatic test_stream();
    word_t want;
    for (int a = 0; a < 3; a++) begin
      p0(1'b0, 1'b0, 4'hf, addr_t'(a), word_t'(32'h11 * (a + 1)));
      cycle();
    end
    p0(1'b1, 1'b1, '0, '0, '0);
    csb1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      want = word_t'(32'h11 * (k + 1));
      cycle();
      total++; if (dout1 !== want) $display("FAIL stream_%0d got %h want %h", k, dout1, want); else passed++;
    end
  endtask

  task automatic test_wrap();
    int bad = 0;
    for (int k = 3; k < DEPTH; k++) begin
      cycle();
      total++;
      if (dout1 !== exp1) begin
        bad++;
        if (bad < 5) $display("FAIL wrap_read_%0d got %h want %h", k, dout1, exp1);
      end else passed++;
    end
    cycle();
    total++; if (dout1 !== 32'h11) $display("FAIL wrap_to_zero got %h want %h", dout1, 32'h11); else passed++;
    csb1 = 1'b1;
  endtask

  task automatic test_collision();
    p0(1'b0, 1'b0, 4'hf, 10'd1, 32'hdeadbeef);
    csb1 = 1'b0;
    cycle();
    total++; if (dout1 !== 32'h22) $display("FAIL collision_old got %h want %h", dout1, 32'h22); else passed++;
    csb1 = 1'b1;
    p0(1'b0, 1'b1, '0, 10'd1, '0);
    cycle();
    total++; if (dout0 !== 32'hdeadbeef) $display("FAIL collision_write got %h want %h", dout0, 32'hdeadbeef); else passed++;
  endtask

  task automatic test_random();
    int bad = 0;
    for (int k = 0; k < 400; k++) begin
      p0(1'($urandom), 1'($urandom), wmask_t'($urandom), addr_t'($urandom_range(0, 15)), word_t'($urandom));
      csb1 = 1'($urandom);
      cycle();
      total += 2;
      if (dout0 !== exp0) begin
        bad++;
        if (bad < 5) $display("FAIL rand_dout0_%0d got %h want %h", k, dout0, exp0);
      end else passed++;
      if (dout1 !== exp1) begin
        bad++;
        if (bad < 5) $display("FAIL rand_dout1_%0d got %h want %h", k, dout1, exp1);
      end else passed++;
    end
  endtask

  task automatic test_reset_midstream();
    p0(1'b0, 1'b1, '0, 10'd5, '0);
    csb1 = 1'b0;
    cycle();
    cycle();
    #2 rst = 1'b1;
    #1;
    total++; if (dout0 !== 32'h0) $display("FAIL midrst_dout0 got %h want %h", dout0, 32'h0); else passed++;
    total++; if (dout1 !== 32'h0) $display("FAIL midrst_dout1 got %h want %h", dout1, 32'h0); else passed++;
    exp0 = '0; exp1 = '0; ptr = 0;
    p0(1'b1, 1'b1, '0, '0, '0);
    csb1 = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    cycle();
    total++; if (dout0 !== 32'h0) $display("FAIL post_rst_hold got %h want %h", dout0, 32'h0); else passed++;
    csb1 = 1'b0;
    cycle();
    total++; if (dout1 !== m[0]) $display("FAIL post_rst_ptr got %h want %h", dout1, m[0]); else passed++;
    csb1 = 1'b1;
    p0(1'b0, 1'b1, '0, 10'd0, '0);
    cycle();
    total++; if (dout0 !== m[0]) $display("FAIL retain_0 got %h want %h", dout0, m[0]); else passed++;
    p0(1'b0, 1'b1, '0, 10'd5, '0);
    cycle();
    total++; if (dout0 !== m[5]) $display("FAIL retain_5 got %h want %h", dout0, m[5]); else passed++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_masked_write();
    test_stream();
    test_wrap();
    test_collision();
    test_random();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
